term_cfg_loopback: RTL and testbench



---
 rtl/term_cfg_pkg.sv | 35 +++
 rtl/term_cfg_loopback_if.sv | 33 +++
 rtl/term_cfg_chain.sv | 56 +++++
 rtl/term_cfg_loopback.sv | 141 ++++++++++++++
 tb/tb_term_cfg_loopback.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/term_cfg_pkg.sv
// -----------------------------------------------------------------------------
// term_cfg_pkg
// Shared types and constants for the south-terminal loopback tile core.
//   state_t      : configuration FSM states (RUN / SHIFT / COMMIT)
//   MODE_*       : 2-bit per-channel output mode encodings
//   channel_out  : per-channel output selection for a given mode
// -----------------------------------------------------------------------------
package term_cfg_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_REG  = 2'b01;
   localparam logic [1:0] MODE_C0   = 2'b10;
   localparam logic [1:0] MODE_C1   = 2'b11;

   // Output of one channel given its mode, its live input and its pipe bit.
   function automatic logic channel_out(input logic [1:0] mode,
                                        input logic       s_bit,
                                        input logic       p_bit);
      logic res;
      case (mode)
         MODE_PASS: res = s_bit;
         MODE_REG:  res = p_bit;
         MODE_C0:   res = 1'b0;
         default:   res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/term_cfg_loopback_if.sv
// -----------------------------------------------------------------------------
// term_cfg_loopback_if
// Bundle of the configuration chain and loopback data signals.
//   MODE     : 1 = configuration shift, 0 = operation
//   CONFin   : serial configuration data in
//   CONFout  : serial configuration data out (chain MSB)
//   S_END    : southbound wire ends [NCH]
//   N_BEG    : northbound wire begins [NCH]
//   CFG_OK   : last commit carried exactly the expected bit count
//   CFG_BUSY : high whenever the core is not in RUN
// Modports: master drives MODE/CONFin/S_END, slave is the tile core.
// -----------------------------------------------------------------------------
interface term_cfg_loopback_if #(
   parameter int NCH = 52
);
   logic           MODE;
   logic           CONFin;
   logic           CONFout;
   logic [NCH-1:0] S_END;
   logic [NCH-1:0] N_BEG;
   logic           CFG_OK;
   logic           CFG_BUSY;

   modport master (
      output MODE, CONFin, S_END,
      input  CONFout, N_BEG, CFG_OK, CFG_BUSY
   );

   modport slave (
      input  MODE, CONFin, S_END,
      output CONFout, N_BEG, CFG_OK, CFG_BUSY
   );
endinterface

// File: rtl/term_cfg_chain.sv
// -----------------------------------------------------------------------------
// term_cfg_chain
// Shadow configuration shift chain with a saturating shifted-bit counter.
//   CLK, RST   : clock, asynchronous active-high reset
//   shift_en   : shift conf_in into the chain LSB this cycle
//   cnt_first  : this shift starts a new load (counter restarts at 1)
//   cnt_clear  : clear the counter (commit cycle)
//   conf_in    : serial data in
//   chain      : full shadow chain contents
//   cnt        : shifted-bit count, saturates at NO_CONFIG_BITS+1
//   conf_out   : chain MSB
// -----------------------------------------------------------------------------
module term_cfg_chain #(
   parameter int NO_CONFIG_BITS = 104,
   parameter int CNT_W          = $clog2(NO_CONFIG_BITS + 2)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      shift_en,
   input  logic                      cnt_first,
   input  logic                      cnt_clear,
   input  logic                      conf_in,
   output logic [NO_CONFIG_BITS-1:0] chain,
   output logic [CNT_W-1:0]          cnt,
   output logic                      conf_out
);

   // One past the expected length marks an over-long load.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NO_CONFIG_BITS + 1);

   // NOTE: the shadow chain is a plain register bank, so it is reset with the
   // rest of the state; an aborted load must never leave stale bits on CONFout.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         chain <= '0;
         cnt   <= '0;
      end else begin
         if (shift_en) begin
            chain <= {chain[NO_CONFIG_BITS-2:0], conf_in};
         end

         if (cnt_clear) begin
            cnt <= '0;
         end else if (cnt_first) begin
            cnt <= CNT_W'(1);
         end else if (shift_en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign conf_out = chain[NO_CONFIG_BITS-1];

endmodule

// File: rtl/term_cfg_loopback.sv
// -----------------------------------------------------------------------------
// term_cfg_loopback
// South-terminal tile core: loops NCH southbound wire ends back north, each
// channel in its own configured mode (pass / registered / const 0 / const 1).
// Configuration is shifted into a shadow chain while MODE=1 and committed
// atomically only when exactly NO_CONFIG_BITS bits were shifted.
//   CLK  : single clock
//   RST  : asynchronous, active-high reset
//   bus  : term_cfg_loopback_if.slave (MODE, CONFin, CONFout, S_END, N_BEG,
//          CFG_OK, CFG_BUSY)
// -----------------------------------------------------------------------------
module term_cfg_loopback
   import term_cfg_pkg::*;
#(
   parameter int NCH = 52
) (
   input  logic               CLK,
   input  logic               RST,
   term_cfg_loopback_if.slave bus
);

   localparam int NO_CONFIG_BITS = 2 * NCH;
   localparam int CNT_W          = $clog2(NO_CONFIG_BITS + 2);

   state_t                    state;
   state_t                    state_next;
   logic                      run;
   logic                      shift_en;
   logic                      cnt_first;
   logic                      cnt_clear;
   logic                      commit;
   logic [NO_CONFIG_BITS-1:0] chain;
   logic [NO_CONFIG_BITS-1:0] active;
   logic [CNT_W-1:0]          cnt;
   logic                      conf_out;
   logic [NCH-1:0]            pipe;
   logic [NCH-1:0]            mux_out;
   logic                      cfg_ok;

   // ---------------------------------------------------------------- chain
   term_cfg_chain #(
      .NO_CONFIG_BITS (NO_CONFIG_BITS),
      .CNT_W          (CNT_W)
   ) u_chain (
      .CLK       (CLK),
      .RST       (RST),
      .shift_en  (shift_en),
      .cnt_first (cnt_first),
      .cnt_clear (cnt_clear),
      .conf_in   (bus.CONFin),
      .chain     (chain),
      .cnt       (cnt),
      .conf_out  (conf_out)
   );

   // ------------------------------------------------------ state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------- next state
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (bus.MODE)  state_next = SHIFT;
         SHIFT:   if (!bus.MODE) state_next = COMMIT;
         COMMIT:  state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // ------------------------------------------------------------- outputs
   always_comb begin
      run       = 1'b0;
      shift_en  = 1'b0;
      cnt_first = 1'b0;
      cnt_clear = 1'b0;
      commit    = 1'b0;
      case (state)
         RUN: begin
            run       = 1'b1;
            shift_en  = bus.MODE;
            cnt_first = bus.MODE;
         end
         SHIFT: begin
            shift_en  = bus.MODE;
         end
         COMMIT: begin
            cnt_clear = 1'b1;
            commit    = 1'b1;
         end
         default: begin
            cnt_clear = 1'b1;
         end
      endcase
   end

   // ------------------------------------- active config, status and pipe
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         active <= '0;
         cfg_ok <= 1'b0;
         pipe   <= '0;
      end else begin
         if (commit) begin
            // Only a load of exactly the chain length may reach the outputs.
            if (cnt == CNT_W'(NO_CONFIG_BITS)) begin
               active <= chain;
               cfg_ok <= 1'b1;
            end else begin
               cfg_ok <= 1'b0;
            end
         end

         // Pipe only tracks S_END while staying in RUN, so registered
         // channels restart from 0 after every configuration episode.
         if (run && !bus.MODE) begin
            pipe <= bus.S_END;
         end else begin
            pipe <= '0;
         end
      end
   end

   // ------------------------------------------------ per-channel out mux
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign mux_out[i] = channel_out(active[2*i+1 -: 2], bus.S_END[i], pipe[i]);
   end

   assign bus.N_BEG    = run ? mux_out : '0;
   assign bus.CFG_OK   = cfg_ok;
   assign bus.CFG_BUSY = !run;
   assign bus.CONFout  = conf_out;

endmodule

// File: tb/tb_term_cfg_loopback.sv
// -----------------------------------------------------------------------------
// tb_term_cfg_loopback
// Self-checking bench for term_cfg_loopback with NCH=4.
// -----------------------------------------------------------------------------
module tb_term_cfg_loopback;

   localparam int NCH = 4;

   typedef struct {
      logic [NCH-1:0] s_end;
      logic [NCH-1:0] n_beg;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   term_cfg_loopback_if #(.NCH(NCH)) bus ();

   term_cfg_loopback #(.NCH(NCH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive S_END for one cycle, check N_BEG combinationally, advance a cycle.
   task automatic apply_vec(input string name, input vec_t v);
      bus.S_END = v.s_end;
      #1;
      check(name, 32'(bus.N_BEG), 32'(v.n_beg));
      @(posedge clk);
      #1;
   endtask

   // Shift n bits (first bit = bits[n-1]) then drop MODE and run through
   // COMMIT; returns positioned in the first RUN cycle after COMMIT.
   task automatic load(input logic [15:0] bits, input int n,
                       input logic exp_ok, input logic [7:0] exp_active);
      int exp_cnt;
      bus.S_END = 4'b1111;
      for (int i = 0; i < n; i++) begin
         bus.MODE   = 1'b1;
         bus.CONFin = bits[n-1-i];
         @(posedge clk);
         #1;
         check("shift_busy", 32'(bus.CFG_BUSY), 32'd1);
         check("shift_nbeg", 32'(bus.N_BEG), 32'd0);
         if (i == 7) check("confout_first_bit", 32'(bus.CONFout), 32'(bits[n-1]));
      end
      exp_cnt = (n > 9) ? 9 : n;
      check("shift_cnt", 32'(dut.u_chain.cnt), 32'(exp_cnt));
      bus.MODE   = 1'b0;
      bus.CONFin = 1'b0;
      @(posedge clk);
      #1;
      check("commit_busy", 32'(bus.CFG_BUSY), 32'd1);
      check("commit_nbeg", 32'(bus.N_BEG), 32'd0);
      @(posedge clk);
      #1;
      check("run_busy", 32'(bus.CFG_BUSY), 32'd0);
      check("cfg_ok", 32'(bus.CFG_OK), 32'(exp_ok));
      check("active", 32'(dut.active), 32'(exp_active));
   endtask

   vec_t pass_tbl [4];
   vec_t cfg1_tbl [6];
   vec_t cfg2_tbl [2];

   initial begin
      checks = 0;
      errors = 0;

      // Reset mapping: every channel passes straight through.
      pass_tbl[0] = '{4'b1010, 4'b1010};
      pass_tbl[1] = '{4'b0101, 4'b0101};
      pass_tbl[2] = '{4'b1111, 4'b1111};
      pass_tbl[3] = '{4'b0000, 4'b0000};
      // Config 01101100: ch0 pass, ch1 const1, ch2 const0, ch3 registered.
      cfg1_tbl[0] = '{4'b1111, 4'b0011};
      cfg1_tbl[1] = '{4'b1111, 4'b1011};
      cfg1_tbl[2] = '{4'b0000, 4'b1010};
      cfg1_tbl[3] = '{4'b1000, 4'b0010};
      cfg1_tbl[4] = '{4'b0001, 4'b1011};
      cfg1_tbl[5] = '{4'b0110, 4'b0010};
      // Config 11011000: ch0 pass, ch1 const0, ch2 registered, ch3 const1.
      cfg2_tbl[0] = '{4'b0101, 4'b1001};
      cfg2_tbl[1] = '{4'b0000, 4'b1100};

      rst        = 1'b1;
      bus.MODE   = 1'b0;
      bus.CONFin = 1'b0;
      bus.S_END  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      bus.S_END = 4'b1010;
      #1;
      check("reset_nbeg", 32'(bus.N_BEG), 32'b1010);
      check("reset_cfg_ok", 32'(bus.CFG_OK), 32'd0);
      check("reset_busy", 32'(bus.CFG_BUSY), 32'd0);
      check("reset_confout", 32'(bus.CONFout), 32'd0);
      for (int i = 0; i < 4; i++) apply_vec("pass_tbl", pass_tbl[i]);

      // Full 8-bit load.
      load(16'b01101100, 8, 1'b1, 8'b01101100);
      for (int i = 0; i < 6; i++) apply_vec("cfg1_tbl", cfg1_tbl[i]);

      // Short load (7 bits): rejected, prior mapping resumes.
      load(16'b1111111, 7, 1'b0, 8'b01101100);
      for (int i = 0; i < 2; i++) apply_vec("short_tbl", cfg1_tbl[i]);

      // Long load (9 bits): counter saturates, rejected.
      load(16'b011111111, 9, 1'b0, 8'b01101100);
      check("long_confout", 32'(bus.CONFout), 32'd1);
      for (int i = 0; i < 2; i++) apply_vec("long_tbl", cfg1_tbl[i]);

      // Single-cycle MODE pulse: cnt=1, rejected.
      load(16'b1, 1, 1'b0, 8'b01101100);

      // Second good load with a different mapping.
      load(16'b11011000, 8, 1'b1, 8'b11011000);
      for (int i = 0; i < 2; i++) apply_vec("cfg2_tbl", cfg2_tbl[i]);

      // Reset in the middle of a load.
      bus.S_END = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         bus.MODE   = 1'b1;
         bus.CONFin = 1'b1;
         @(posedge clk);
         #1;
      end
      check("abort_pre_confout", 32'(bus.CONFout), 32'd1);
      check("abort_pre_busy", 32'(bus.CFG_BUSY), 32'd1);
      rst       = 1'b1;
      bus.MODE  = 1'b0;
      bus.S_END = 4'b1010;
      #1;
      check("abort_nbeg", 32'(bus.N_BEG), 32'b1010);
      check("abort_cfg_ok", 32'(bus.CFG_OK), 32'd0);
      check("abort_confout", 32'(bus.CONFout), 32'd0);
      check("abort_busy", 32'(bus.CFG_BUSY), 32'd0);
      check("abort_active", 32'(dut.active), 32'd0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Load after abort succeeds.
      load(16'b01101100, 8, 1'b1, 8'b01101100);
      for (int i = 0; i < 2; i++) apply_vec("reload_tbl", cfg1_tbl[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
